// File: rtl/mul_pipe_unit.sv
// mul_pipe_unit: pipelined RV32M/RV64M multiplier (MUL, MULH, MULHSU, MULHU).
//
// Operands are extended to XLEN+1 bits (sign or zero per mode). rs2 is split
// into an unsigned low half and a signed high part, and the two partial
// products are captured in the first stage. The partials are summed on the way
// into the second stage; any later stages only carry the product. Results
// leave strictly in accept order, with latency NUM_STAGE when unstalled.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   in_valid_i / in_ready_o  operation handshake (ready = not stalled)
//   opcode_i, funct7_i,
//   funct3_i                 instruction fields used for decode and mode
//   mult_in1_i, mult_in2_i   rs1 / rs2 operands
//   tag_i                    opaque tag (rd address) carried with the op
//   flush_i                  drop every in-flight op
//   out_valid_o/out_ready_i  result handshake
//   result_o, tag_o          selected product half and its tag
module mul_pipe_unit #(
  parameter int XLEN      = 32,
  parameter int NUM_STAGE = 2,
  parameter int TAG_W     = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [6:0]       opcode_i,
  input  logic [6:0]       funct7_i,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  mult_in1_i,
  input  logic [XLEN-1:0]  mult_in2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int PW   = 2 * XLEN;       // product width kept in the pipe
  localparam int HW   = XLEN / 2;       // width of the unsigned low rs2 slice
  localparam int BHW  = XLEN + 1 - HW;  // width of the signed high rs2 slice
  localparam int LAST = NUM_STAGE - 1;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  typedef enum logic [1:0] {
    MODE_MUL    = 2'b00,
    MODE_MULH   = 2'b01,
    MODE_MULHSU = 2'b10,
    MODE_MULHU  = 2'b11
  } mode_t;

  // ---------------------------------------------------------------------------
  // Decode and handshake
  // ---------------------------------------------------------------------------
  logic  dec_hit;
  logic  stall;
  logic  accept;
  mode_t mode_in;

  assign dec_hit = (opcode_i == OPC_OP) && (funct7_i == F7_MULDIV) && !funct3_i[2];
  assign mode_in = mode_t'(funct3_i[1:0]);

  assign stall      = out_valid_o && !out_ready_i;
  assign in_ready_o = !stall;
  // Non-multiply ops with in_valid_i are consumed silently: ready stays high
  // and nothing enters the pipe.
  assign accept     = in_valid_i && in_ready_o && dec_hit && !flush_i;

  // ---------------------------------------------------------------------------
  // Operand extension and partial products
  // ---------------------------------------------------------------------------
  logic          a_sgn;
  logic          b_sgn;
  logic [XLEN:0] a_ext;
  logic [XLEN:0] b_ext;
  logic [PW-1:0] a_w;
  logic [PW-1:0] b_lo_w;
  logic [PW-1:0] b_hi_w;
  logic [PW-1:0] pp_lo;
  logic [PW-1:0] pp_hi;

  always_comb begin
    a_sgn = (mode_in != MODE_MULHU);
    b_sgn = (mode_in == MODE_MUL) || (mode_in == MODE_MULH);
    a_ext = {a_sgn & mult_in1_i[XLEN-1], mult_in1_i};
    b_ext = {b_sgn & mult_in2_i[XLEN-1], mult_in2_i};
  end

  // Everything is carried modulo 2^PW: sign-extending the XLEN+1-bit operands
  // explicitly lets plain unsigned multiplies produce the two's-complement
  // product bits that are actually returned.
  assign a_w    = {{(PW - XLEN - 1){a_ext[XLEN]}}, a_ext};
  assign b_lo_w = {{(PW - HW){1'b0}}, b_ext[HW-1:0]};
  assign b_hi_w = {{(PW - BHW){b_ext[XLEN]}}, b_ext[XLEN:HW]};

  assign pp_lo = a_w * b_lo_w;
  assign pp_hi = a_w * b_hi_w;

  // ---------------------------------------------------------------------------
  // Pipeline stages
  // ---------------------------------------------------------------------------
  logic             vld_q  [NUM_STAGE];
  logic [PW-1:0]    lo_q   [NUM_STAGE];
  logic [PW-1:0]    hi_q   [NUM_STAGE];
  mode_t            mode_q [NUM_STAGE];
  logic [TAG_W-1:0] tag_q  [NUM_STAGE];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NUM_STAGE; k++) begin
        vld_q[k]  <= 1'b0;
        lo_q[k]   <= '0;
        hi_q[k]   <= '0;
        mode_q[k] <= MODE_MUL;
        tag_q[k]  <= '0;
      end
    end else begin
      // Valid bits: flush wins over stall; a stall freezes every stage,
      // bubbles included.
      if (flush_i) begin
        for (int unsigned k = 0; k < NUM_STAGE; k++) begin
          vld_q[k] <= 1'b0;
        end
      end else if (!stall) begin
        vld_q[0] <= accept;
        for (int unsigned k = 1; k < NUM_STAGE; k++) begin
          vld_q[k] <= vld_q[k-1];
        end
      end

      // Payload only moves behind a valid op, so idle stages do not toggle.
      if (!stall) begin
        if (accept) begin
          lo_q[0]   <= pp_lo;
          hi_q[0]   <= pp_hi;
          mode_q[0] <= mode_in;
          tag_q[0]  <= tag_i;
        end
        for (int unsigned k = 1; k < NUM_STAGE; k++) begin
          if (vld_q[k-1]) begin
            if (k == 1) begin
              lo_q[k] <= lo_q[0] + (hi_q[0] << HW);
              hi_q[k] <= '0;
            end else begin
              lo_q[k] <= lo_q[k-1];
              hi_q[k] <= hi_q[k-1];
            end
            mode_q[k] <= mode_q[k-1];
            tag_q[k]  <= tag_q[k-1];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output selection
  // ---------------------------------------------------------------------------
  // hi_q of the last stage is zero whenever NUM_STAGE > 1, so the same
  // recombination serves the single-stage build where the partials are still
  // separate at the output.
  logic [PW-1:0] prod_out;

  always_comb begin
    prod_out = lo_q[LAST] + (hi_q[LAST] << HW);
    if (mode_q[LAST] == MODE_MUL) begin
      result_o = prod_out[XLEN-1:0];
    end else begin
      result_o = prod_out[PW-1:XLEN];
    end
  end

  assign out_valid_o = vld_q[LAST];
  assign tag_o       = tag_q[LAST];

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Self-checking bench for mul_pipe_unit (XLEN=32, NUM_STAGE=2, TAG_W=5).
// A queue model of in-flight ops predicts out_valid/in_ready/result/tag every
// cycle; directed sequences add literal expectations on what was delivered.
module tb_mul_pipe_unit;

  localparam int XLEN = 32;
  localparam int NS   = 2;
  localparam int TW   = 5;

  logic            clk_i;
  logic            rst_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [6:0]      opcode_i;
  logic [6:0]      funct7_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] mult_in1_i;
  logic [XLEN-1:0] mult_in2_i;
  logic [TW-1:0]   tag_i;
  logic            flush_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] result_o;
  logic [TW-1:0]   tag_o;

  mul_pipe_unit #(.XLEN(XLEN), .NUM_STAGE(NS), .TAG_W(TW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .opcode_i    (opcode_i),
    .funct7_i    (funct7_i),
    .funct3_i    (funct3_i),
    .mult_in1_i  (mult_in1_i),
    .mult_in2_i  (mult_in2_i),
    .tag_i       (tag_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .tag_o       (tag_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit chk_en   = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          age;
  } item_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          cyc;
  } obs_t;

  item_t q[$];
  obs_t  seen[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Full-width reference product with the mode's operand signedness.
  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = (f3 == 3'd3) ? longint'(a) : longint'($signed(a));
    sb = (f3 == 3'd2 || f3 == 3'd3) ? longint'(b) : longint'($signed(b));
    p  = sa * sb;
    return (f3 == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  // Compare process: outputs checked on the falling edge, then the model is
  // advanced to the state following the next rising edge.
  always @(negedge clk_i) begin
    logic  ev, er;
    item_t it;
    ev = (q.size() > 0) && (q[0].age >= NS);
    er = !(ev && !out_ready_i);
    if (chk_en) begin
      chk("out_valid", out_valid_o, ev);
      chk("in_ready", in_ready_o, er);
      if (ev) begin
        chk("result", result_o, q[0].res);
        chk("tag", tag_o, q[0].tag);
      end
      if (out_valid_o && out_ready_i) seen.push_back('{result_o, tag_o, cyc});
    end
    if (rst_i || flush_i) begin
      q.delete();
    end else if (er) begin
      if (ev) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (in_valid_i && opcode_i == 7'b0110011 && funct7_i == 7'h01 && !funct3_i[2]) begin
        it.res = ref_mul(funct3_i, mult_in1_i, mult_in2_i);
        it.tag = tag_i;
        it.age = 1;
        q.push_back(it);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    in_valid_i = 1'b1;
    opcode_i   = 7'b0110011;
    funct7_i   = 7'h01;
    funct3_i   = f3;
    mult_in1_i = a;
    mult_in2_i = b;
    tag_i      = t;
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
  endtask

  initial begin : stim
    int          base, n0, idx;
    logic        acc;
    logic [31:0] exp2 [4];
    exp2[0] = 32'h0000_0000;
    exp2[1] = 32'h4000_0000;
    exp2[2] = 32'hC000_0000;
    exp2[3] = 32'h4000_0000;

    rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
    in_valid_i = 1'b0; opcode_i = 7'b0110011; funct7_i = 7'h01; funct3_i = 3'd0;
    mult_in1_i = '0; mult_in2_i = '0; tag_i = '0;

    // Model pins: hand-computed products.
    chk("pin_mul", ref_mul(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("pin_mulhsu", ref_mul(3'd2, 32'h8000_0000, 32'h8000_0000), 32'hC000_0000);
    chk("pin_mulhu", ref_mul(3'd3, 32'hFFFF_FFFF, 32'd6), 32'd5);

    repeat (3) tick();
    chk("rst_valid", out_valid_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_tag", tag_o, 0);
    chk("rst_ready", in_ready_o, 1);
    rst_i  = 1'b0;
    chk_en = 1'b1;
    repeat (2) tick();

    // 1: single MUL, latency 2, one delivery
    base = seen.size();
    drive(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3);
    n0 = cyc;
    tick(); idle(); repeat (4) tick();
    chk("t1_count", seen.size() - base, 1);
    if (seen.size() > base) begin
      chk("t1_result", seen[base].res, 32'hFFFF_FFEB);
      chk("t1_tag", seen[base].tag, 3);
      chk("t1_latency", seen[base].cyc - n0, NS);
    end

    // 2: four modes back to back on 0x80000000 x 0x80000000
    base = seen.size();
    for (int i = 0; i < 4; i++) begin
      drive(3'(i), 32'h8000_0000, 32'h8000_0000, 5'(4 + i));
      tick();
    end
    idle(); repeat (4) tick();
    chk("t2_count", seen.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (seen.size() > base + i) begin
        chk("t2_result", seen[base + i].res, exp2[i]);
        chk("t2_tag", seen[base + i].tag, 4 + i);
      end
    end

    // 3: five MULHU with 3 cycles of backpressure on the first result
    base = seen.size();
    idx  = 0;
    for (int c = 0; c < 14; c++) begin
      out_ready_i = !(c >= 2 && c <= 4);
      if (idx < 5) drive(3'd3, 32'hFFFF_FFFF, 32'(2 + idx), 5'(10 + idx));
      else idle();
      #1;
      acc = in_valid_i && in_ready_o;
      if (c >= 2 && c <= 4) begin
        chk("t3_stall_valid", out_valid_o, 1);
        chk("t3_stall_ready", in_ready_o, 0);
        chk("t3_stall_result", result_o, 1);
        chk("t3_stall_tag", tag_o, 10);
      end
      @(posedge clk_i);
      #1;
      if (acc) idx++;
    end
    out_ready_i = 1'b1;
    idle();
    chk("t3_issued", idx, 5);
    chk("t3_count", seen.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      if (seen.size() > base + i) begin
        chk("t3_result", seen[base + i].res, 1 + i);
        chk("t3_tag", seen[base + i].tag, 10 + i);
      end
    end

    // 4: flush with two ops in flight and a third offered
    base = seen.size();
    drive(3'd0, 32'd3, 32'd5, 5'd20); tick();
    drive(3'd0, 32'd4, 32'd5, 5'd21); tick();
    out_ready_i = 1'b0;
    flush_i     = 1'b1;
    drive(3'd0, 32'd6, 32'd5, 5'd22);
    tick();
    flush_i = 1'b0; out_ready_i = 1'b1; idle();
    repeat (3) tick();
    // flush with an idle pipe blocks an otherwise acceptable op
    flush_i = 1'b1;
    drive(3'd0, 32'd8, 32'd5, 5'd19);
    tick();
    flush_i = 1'b0; idle();
    repeat (3) tick();
    chk("t4_flushed", seen.size() - base, 0);
    drive(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 5'd23);
    n0 = cyc;
    tick(); idle(); repeat (3) tick();
    chk("t4_count", seen.size() - base, 1);
    if (seen.size() > base) begin
      chk("t4_result", seen[base].res, 32'hFFFF_FFFF);
      chk("t4_latency", seen[base].cyc - n0, NS);
    end

    // 5: DIV consumed silently, then MUL -1 x -1
    base = seen.size();
    drive(3'd4, 32'd100, 32'd7, 5'd24);
    #1;
    chk("t5_div_ready", in_ready_o, 1);
    tick();
    drive(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd25);
    tick(); idle(); repeat (4) tick();
    chk("t5_count", seen.size() - base, 1);
    if (seen.size() > base) begin
      chk("t5_result", seen[base].res, 32'h0000_0001);
      chk("t5_tag", seen[base].tag, 25);
    end

    // 6: reset with an op in the first stage
    base = seen.size();
    drive(3'd0, 32'd7, 32'd7, 5'd26);
    tick(); idle();
    rst_i = 1'b1;
    tick();
    chk("t6_valid", out_valid_o, 0);
    chk("t6_result", result_o, 0);
    chk("t6_tag", tag_o, 0);
    rst_i = 1'b0;
    #1;
    chk("t6_ready", in_ready_o, 1);
    repeat (4) tick();
    chk("t6_dropped", seen.size() - base, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
